// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus responder: MMIO register offsets, register bit
// positions and the region selector produced by the address decoder.
package dbus_pkg;

    // Byte offsets of the word registers inside the MMIO window
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_CYCLES = 4'hC;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_MMIO,
        SEL_NONE
    } region_e;

    function automatic logic [31:0] pack_status(input logic [7:0] count, input logic ovf,
                                                input logic full, input logic empty);
        logic [31:0] s;
        s                          = '0;
        s[ST_COUNT_LSB +: 8]       = count;
        s[ST_OVF]                  = ovf;
        s[ST_FULL]                 = full;
        s[ST_EMPTY]                = empty;
        return s;
    endfunction

endpackage

// File: rtl/dbus_responder_sync_fifo.sv
// Synchronous FIFO with flush; the head entry is shown on rdata, forced to zero while
// empty so the output has a defined value straight out of reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO only lands when the head leaves in the same cycle
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; pointers and count define which
    // entries are live, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dbus_responder.sv
// Responder on the single-cycle core's data port: word RAM plus an MMIO window with a
// TX byte FIFO, STATUS/CTRL registers and a loadable free-running cycle counter.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    region_e        sel;
    logic [3:0]     off;
    logic [31:0]    ram [RAM_WORDS];
    logic [31:0]    cycles;
    logic           ovf;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           push;
    logic           pop;
    logic           flush;
    logic           clr_ovf;
    logic           cycles_we;
    logic           mmio_we;
    logic           unused;

    assign unused = ^a[1:0];
    assign off    = {a[3:2], 2'b00};

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        sel = SEL_NONE;
        if (a[31:AW+2] == '0)
            sel = SEL_RAM;
        else if (a[31:4] == MMIO_BASE[31:4])
            sel = SEL_MMIO;
    end

    assign mmio_we   = we && (sel == SEL_MMIO);
    assign push      = mmio_we && (off == OFF_TXDATA);
    assign flush     = mmio_we && (off == OFF_CTRL) && wd[CTRL_FLUSH];
    assign clr_ovf   = mmio_we && (off == OFF_CTRL) && wd[CTRL_CLR_OVF];
    assign cycles_we = mmio_we && (off == OFF_CYCLES);

    assign tx_valid = !fifo_empty;
    assign pop      = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wd[7:0]),
        .rdata (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Overflow marks a byte lost to a full FIFO that was not draining that cycle
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (clr_ovf)
            ovf <= 1'b0;
        else if (push && fifo_full && !pop)
            ovf <= 1'b1;
    end

    // A load counts its own cycle, so the value written reads back one higher
    always_ff @(posedge clk) begin
        if (reset)
            cycles <= '0;
        else if (cycles_we)
            cycles <= wd + 32'd1;
        else
            cycles <= cycles + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (we && (sel == SEL_RAM)) ram[a[AW+1:2]] <= wd;
    end

    always_comb begin
        rd = '0;
        case (sel)
            SEL_RAM: rd = ram[a[AW+1:2]];
            SEL_MMIO: begin
                case (off)
                    OFF_STATUS: rd = pack_status(8'(fifo_count), ovf, fifo_full, fifo_empty);
                    OFF_CYCLES: rd = cycles;
                    default:    rd = '0;
                endcase
            end
            default: rd = '0;
        endcase
    end

endmodule
